// File: rtl/div_issue_ctrl.sv
// EX-stage requester for the iterative divider: holds operands stable, waits for
// the done handshake and strobes the 64-bit result into HI/LO.

`ifndef FUNCT_BUS
`define FUNCT_BUS 5:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef DOUBLE_DATA_BUS
`define DOUBLE_DATA_BUS 63:0
`endif
`ifndef FUNCT_DIV
`define FUNCT_DIV 6'b011010
`endif
`ifndef FUNCT_DIVU
`define FUNCT_DIVU 6'b011011
`endif

module div_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     div_req,
  input  logic [`FUNCT_BUS]        funct,
  input  logic [`DATA_BUS]         operand_1,
  input  logic [`DATA_BUS]         operand_2,
  input  logic                     flush,
  output logic                     div_en,
  output logic [`FUNCT_BUS]        div_funct,
  output logic [`DATA_BUS]         div_op1,
  output logic [`DATA_BUS]         div_op2,
  input  logic                     done,
  input  logic [`DOUBLE_DATA_BUS]  result_div,
  output logic                     stall_req,
  output logic                     hilo_we,
  output logic [`DATA_BUS]         hi_wdata,
  output logic [`DATA_BUS]         lo_wdata,
  output logic                     div_err
);

  typedef enum logic [1:0] {StIdle, StWait, StWrite} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [`FUNCT_BUS] funct_q, funct_d;
  logic [`DATA_BUS] op1_q, op1_d;
  logic [`DATA_BUS] op2_q, op2_d;
  logic [`DATA_BUS] hi_q, hi_d;
  logic [`DATA_BUS] lo_q, lo_d;
  logic             err_q, err_d;
  logic             timeout;
  logic             accept;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign accept  = div_req & ~flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    funct_d = funct_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (operand_2 != '0) begin
            funct_d = funct;
            op1_d   = operand_1;
            op2_d   = operand_2;
            cnt_d   = '0;
            state_d = StWait;
          end else begin
            // Divide-by-zero bypasses the divider with a fixed result.
            hi_d    = operand_1;
            lo_d    = '1;
            state_d = StWrite;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // Flush beats done; done beats timeout.
        if (flush) begin
          state_d = StIdle;
        end else if (done) begin
          hi_d    = result_div[63:32];
          lo_d    = result_div[31:0];
          state_d = StWrite;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StWrite: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      funct_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      funct_q <= funct_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  assign div_en    = (state_q == StWait);
  assign div_funct = funct_q;
  assign div_op1   = op1_q;
  assign div_op2   = op2_q;
  assign hi_wdata  = hi_q;
  assign lo_wdata  = lo_q;
  assign div_err   = err_q;
  assign hilo_we   = (state_q == StWrite) & ~flush;
  // Gated by rst_n so the stall drops the moment reset is applied.
  assign stall_req = rst_n & (((state_q == StIdle) & accept) | (state_q == StWait));

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- EX-stage requester for the divide unit.
- Accepts DIV/DIVU instructions from the EX stage and holds their operands stable toward the divider.
- Drives the divider request, waits for its done handshake, then writes the 64-bit result into the HI/LO registers.
- Stalls the pipeline while a divide is outstanding; handles divide-by-zero, pipeline flush and a watchdog timeout.

Parameters:
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before the request is abandoned.
- CNT_W, 7: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- div_req  in  1  EX holds a DIV/DIVU instruction this cycle
- funct  in  `FUNCT_BUS  instruction funct (`FUNCT_DIV signed, `FUNCT_DIVU unsigned)
- operand_1  in  `DATA_BUS  dividend
- operand_2  in  `DATA_BUS  divisor
- flush  in  1  exception/branch flush of EX
- div_en  out  1  request to divider
- div_funct  out  `FUNCT_BUS  latched funct to divider
- div_op1  out  `DATA_BUS  latched dividend
- div_op2  out  `DATA_BUS  latched divisor
- done  in  1  divider result valid
- result_div  in  `DOUBLE_DATA_BUS  {remainder[63:32], quotient[31:0]}
- stall_req  out  1  hold IF/ID/EX
- hilo_we  out  1  one-cycle HI/LO write strobe
- hi_wdata  out  `DATA_BUS  remainder
- lo_wdata  out  `DATA_BUS  quotient
- div_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, rst_n low): state=IDLE, counter=0. div_en, hilo_we, div_err, stall_req, div_op1/2, div_funct, hi/lo_wdata all 0. Reset asserted mid-WAIT aborts with no write.
- States: IDLE, WAIT, WRITE.
- IDLE, div_req=1, flush=0, operand_2!=0:
  - latch operand_1/2 and funct into the div_* outputs;
  - go to WAIT; clear the counter.
- IDLE, div_req=1, flush=0, operand_2==0:
  - no divider request;
  - load hi_wdata=operand_1, lo_wdata=32'hFFFF_FFFF;
  - go to WRITE.
  - Applies to both DIV and DIVU.
- IDLE, flush=1: stay in IDLE, nothing latched.
- WAIT:
  - div_en=1 and div_* outputs held constant.
  - Counter increments every cycle.
  - done=1: capture hi_wdata=result_div[63:32], lo_wdata=result_div[31:0]; go to WRITE. done may be high on the first WAIT cycle.
  - Flush takes priority over done: flush=1 → IDLE, no write.
  - Counter reaching TIMEOUT_CYCLES-1 without done → IDLE, div_err=1 for one cycle, no write. Done wins over timeout in the same cycle.
- WRITE:
  - hilo_we=1 for exactly one cycle, unless flush=1 that cycle, in which case it is suppressed.
  - div_en=0.
  - Always returns to IDLE.
- stall_req (combinational):
  - 1 in IDLE when div_req & ~flush;
  - 1 throughout WAIT;
  - 0 in WRITE, which lets the instruction retire.
  - The instruction therefore leaves EX exactly on the WRITE cycle. A new div_req in the following IDLE cycle is a new instruction.
- Latency, nonzero divisor: request cycle (IDLE) → ≥1 WAIT cycle → WRITE. Minimum 3 cycles, stall high for 2.
- Latency, divide-by-zero: request cycle → WRITE. Stall high for 1 cycle.
- div_en is never asserted outside WAIT. Operands presented to the divider never change while div_en=1.

Test Plan:
- DIVU: operand_1=100, operand_2=7; done driven on 3rd WAIT cycle with result_div={32'd2,32'd14} → div_en high for 3 cycles; stall_req high for 4 cycles; hilo_we pulse with hi=2, lo=14.
- DIV with immediate done: operand_1=-7 (0xFFFFFFF9), operand_2=2; result {0xFFFFFFFF,0xFFFFFFFD} on the first WAIT cycle → WRITE on cycle 3; hi=0xFFFFFFFF, lo=0xFFFFFFFD; div_funct=`FUNCT_DIV throughout.
- Divide-by-zero: operand_1=0x1234, operand_2=0 → div_en never high; stall_req 1 cycle; next cycle hilo_we=1, hi=0x1234, lo=0xFFFFFFFF.
- Flush mid-WAIT: flush=1 on 2nd WAIT cycle while done=1 → return to IDLE; hilo_we stays 0; stall_req drops; no div_err.
- Timeout: done held 0 → after 64 WAIT cycles div_err pulses once; no hilo_we; state IDLE.
- Async reset: rst_n low mid-WAIT between clock edges → div_en and stall_req go to 0 immediately; after release the FSM is IDLE with no write.
